// File: rtl/alu_issue_ctrl.sv
// Operand-issue / result-capture controller for the 8-bit add/sub ALU, with a small register file.
// Optional sticky overflow flag is built when STICKY_OVF_EN is defined.
module alu_issue_ctrl #(
  parameter int REG_CNT = 4,
  parameter int REG_AW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [REG_AW-1:0] req_rd,
  input  logic [REG_AW-1:0] req_rs1,
  input  logic [REG_AW-1:0] req_rs2,
  input  logic [7:0]        req_imm,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic              alu_op,
  input  logic [8:0]        alu_out,
  input  logic              alu_flag_c,
  input  logic              alu_flag_o,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [7:0]        rsp_data,
  output logic              rsp_c,
  output logic              rsp_o,
  output logic              rsp_z,
  output logic              sticky_o,
  input  logic              clr_sticky
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [1:0] OP_SUB = 2'd0;
  localparam logic [1:0] OP_ADD = 2'd1;
  localparam logic [1:0] OP_LDI = 2'd2;
  localparam logic [1:0] OP_RD  = 2'd3;

  state_t            state;
  state_t            next_state;
  logic [7:0]        rf [REG_CNT];
  logic [REG_AW-1:0] rd_q;
  logic              accept;

  assign accept = req_ready && req_valid;

  // req_ready is registered so it stays low during reset and rises one cycle after release
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b0;
    end else begin
      state     <= next_state;
      req_ready <= (next_state == IDLE);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_op == OP_SUB || req_op == OP_ADD) next_state = ISSUE;
          else                                      next_state = RESP;
        end
      end
      ISSUE:   next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    rsp_valid = (state == RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) rf[i] <= 8'd0;
      rd_q     <= '0;
      alu_a    <= 8'd0;
      alu_b    <= 8'd0;
      alu_op   <= 1'b0;
      rsp_data <= 8'd0;
      rsp_c    <= 1'b0;
      rsp_o    <= 1'b0;
      rsp_z    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (req_op)
              OP_SUB, OP_ADD: begin
                alu_a  <= rf[req_rs1];
                alu_b  <= rf[req_rs2];
                alu_op <= (req_op == OP_ADD);
                rd_q   <= req_rd;
              end
              OP_LDI: begin
                rf[req_rd] <= req_imm;
                rsp_data   <= req_imm;
              end
              default: rsp_data <= rf[req_rs1];
            endcase
          end
        end
        // ALU has settled on the registered operands; capture result and flags
        ISSUE: begin
          rf[rd_q] <= alu_out[7:0];
          rsp_data <= alu_out[7:0];
          rsp_c    <= alu_flag_c;
          rsp_o    <= alu_flag_o;
          rsp_z    <= (alu_out[7:0] == 8'd0);
        end
        default: ;
      endcase
    end
  end

`ifdef STICKY_OVF_EN
  // Set has priority over clear when both land on the same edge
  always_ff @(posedge clk) begin
    if (rst)                                sticky_o <= 1'b0;
    else if (state == ISSUE && alu_flag_o) sticky_o <= 1'b1;
    else if (clr_sticky)                    sticky_o <= 1'b0;
  end
  logic unused_bits;
  assign unused_bits = alu_out[8];
`else
  assign sticky_o = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{alu_out[8], clr_sticky};
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl; a behavioural add/sub ALU closes the loop around the DUT.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst, req_valid, req_ready, alu_op, alu_flag_c, alu_flag_o;
  logic [1:0] req_op, req_rd, req_rs1, req_rs2;
  logic [7:0] req_imm, alu_a, alu_b, rsp_data;
  logic [8:0] alu_out;
  logic       rsp_valid, rsp_ready, rsp_c, rsp_o, rsp_z, sticky_o, clr_sticky;
  logic       sticky_exp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.REG_CNT(4), .REG_AW(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .alu_flag_c(alu_flag_c), .alu_flag_o(alu_flag_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_c(rsp_c), .rsp_o(rsp_o), .rsp_z(rsp_z),
    .sticky_o(sticky_o), .clr_sticky(clr_sticky)
  );

  // Reference ALU: carry is bit 8 of the 9-bit result, overflow is two's-complement overflow
  always_comb begin
    alu_out    = 9'd0;
    alu_flag_c = 1'b0;
    alu_flag_o = 1'b0;
    if (alu_op) begin
      alu_out    = {1'b0, alu_a} + {1'b0, alu_b};
      alu_flag_o = (alu_a[7] == alu_b[7]) && (alu_out[7] != alu_a[7]);
    end else begin
      alu_out    = {1'b0, alu_a} - {1'b0, alu_b};
      alu_flag_o = (alu_a[7] != alu_b[7]) && (alu_out[7] != alu_a[7]);
    end
    alu_flag_c = alu_out[8];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge
  task automatic send(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                      input logic [1:0] rs2, input logic [7:0] imm);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input bit is_alu, input logic [7:0] data,
                            input logic c, input logic o, input logic z);
    if (is_alu) begin
      chk({tag, "_lat_issue"}, {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
    end
    chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_data"}, {24'd0, rsp_data}, {24'd0, data});
    chk({tag, "_flags"}, {29'd0, rsp_c, rsp_o, rsp_z}, {29'd0, c, o, z});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_ready_back"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
`ifdef STICKY_OVF_EN
    sticky_exp = 1'b1;
`else
    sticky_exp = 1'b0;
`endif
    rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_rd = 2'd0; req_rs1 = 2'd0;
    req_rs2 = 2'd0; req_imm = 8'd0; rsp_ready = 1'b0; clr_sticky = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // Reset in the middle of an ADD
    send(2'd2, 2'd0, 2'd0, 2'd0, 8'd5);  expect_rsp("ldi5", 1'b0, 8'd5, 1'b0, 1'b0, 1'b0);
    send(2'd2, 2'd1, 2'd0, 2'd0, 8'd3);  expect_rsp("ldi3", 1'b0, 8'd3, 1'b0, 1'b0, 1'b0);
    send(2'd1, 2'd2, 2'd0, 2'd1, 8'd0);
    chk("mid_issue_a", {24'd0, alu_a}, 32'd5);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_alu", {15'd0, alu_a, alu_b, alu_op}, 32'd0);
    chk("rst_rsp", {20'd0, rsp_valid, rsp_data, rsp_c, rsp_o, rsp_z}, 32'd0);
    chk("rst_misc", {30'd0, req_ready, sticky_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_ready", {31'd0, req_ready}, 32'd1);
    send(2'd3, 2'd0, 2'd0, 2'd0, 8'd0);  expect_rsp("rd_r0_rst", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    send(2'd3, 2'd0, 2'd2, 2'd0, 8'd0);  expect_rsp("rd_r2_rst", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

    // Subtraction and zero flag
    send(2'd2, 2'd0, 2'd0, 2'd0, 8'd40); expect_rsp("ldi40", 1'b0, 8'd40, 1'b0, 1'b0, 1'b0);
    send(2'd2, 2'd1, 2'd0, 2'd0, 8'd20); expect_rsp("ldi20", 1'b0, 8'd20, 1'b0, 1'b0, 1'b0);
    send(2'd0, 2'd2, 2'd0, 2'd1, 8'd0);  expect_rsp("sub40_20", 1'b1, 8'd20, 1'b0, 1'b0, 1'b0);
    chk("sub_alu_op", {31'd0, alu_op}, 32'd0);
    send(2'd0, 2'd3, 2'd1, 2'd1, 8'd0);  expect_rsp("sub_zero", 1'b1, 8'd0, 1'b0, 1'b0, 1'b1);
    send(2'd3, 2'd0, 2'd2, 2'd0, 8'd0);  expect_rsp("rd_r2", 1'b0, 8'd20, 1'b0, 1'b0, 1'b1);

    // Unsigned carry out
    send(2'd2, 2'd0, 2'd0, 2'd0, 8'd200); expect_rsp("ldi200", 1'b0, 8'd200, 1'b0, 1'b0, 1'b1);
    send(2'd2, 2'd1, 2'd0, 2'd0, 8'd100); expect_rsp("ldi100", 1'b0, 8'd100, 1'b0, 1'b0, 1'b1);
    send(2'd1, 2'd2, 2'd0, 2'd1, 8'd0);   expect_rsp("add_carry", 1'b1, 8'd44, 1'b1, 1'b0, 1'b0);
    chk("hold_alu", {15'd0, alu_a, alu_b, alu_op}, {15'd0, 8'd200, 8'd100, 1'b1});
    chk("sticky_none", {31'd0, sticky_o}, 32'd0);

    // Signed overflow with rd == rs1
    send(2'd2, 2'd0, 2'd0, 2'd0, 8'd100); expect_rsp("ldi100b", 1'b0, 8'd100, 1'b1, 1'b0, 1'b0);
    send(2'd2, 2'd1, 2'd0, 2'd0, 8'd100); expect_rsp("ldi100c", 1'b0, 8'd100, 1'b1, 1'b0, 1'b0);
    send(2'd1, 2'd0, 2'd0, 2'd1, 8'd0);   expect_rsp("add_ovf", 1'b1, 8'd200, 1'b0, 1'b1, 1'b0);
    send(2'd3, 2'd0, 2'd0, 2'd0, 8'd0);   expect_rsp("rd_r0", 1'b0, 8'd200, 1'b0, 1'b1, 1'b0);
    chk("sticky_set", {31'd0, sticky_o}, {31'd0, sticky_exp});

    // Backpressure: 200 + 1 = 201, pending LDI must wait for the response to drain
    send(2'd2, 2'd1, 2'd0, 2'd0, 8'd1);   expect_rsp("ldi1", 1'b0, 8'd1, 1'b0, 1'b1, 1'b0);
    send(2'd1, 2'd2, 2'd0, 2'd1, 8'd0);
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd2; req_rd = 2'd3; req_imm = 8'd77;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_data", {24'd0, rsp_data}, 32'd201);
      chk("bp_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    chk("bp_flags", {29'd0, rsp_c, rsp_o, rsp_z}, 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_drained", {30'd0, rsp_valid, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp_next_valid", {31'd0, rsp_valid}, 32'd1);
    chk("bp_next_data", {24'd0, rsp_data}, 32'd77);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("sticky_hold", {31'd0, sticky_o}, {31'd0, sticky_exp});

    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    chk("sticky_clr", {31'd0, sticky_o}, 32'd0);
    send(2'd3, 2'd0, 2'd3, 2'd0, 8'd0);   expect_rsp("rd_r3", 1'b0, 8'd77, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
